tdm_demux8: RTL

TDM_DEMUX8 -- requirements
Module: tdm_demux8

---
 rtl/tdm_demux8_if.sv | 22 ++
 rtl/tdm_demux8.sv | 76 +++++++
 2 files changed

// File: rtl/tdm_demux8_if.sv
// Serial TDM input side and recovered-frame output side of tdm_demux8.
// The master modport drives the serial stream; the slave modport is the demux.
interface tdm_demux8_if;
    logic       din;
    logic       din_valid;
    logic       sync;
    logic [7:0] out;
    logic       frame_valid;
    logic [2:0] slot;
    logic       locked;
    logic       sync_err;

    modport master (
        output din, din_valid, sync,
        input  out, frame_valid, slot, locked, sync_err
    );

    modport slave (
        input  din, din_valid, sync,
        output out, frame_valid, slot, locked, sync_err
    );
endinterface

// File: rtl/tdm_demux8.sv
// Purpose: aligns to an 8-slot 1-bit TDM stream via sync and emits each frame in parallel.
// Latency: out/frame_valid update on the edge sampling the slot-7 bit.
// Backpressure: none; din_valid=0 simply freezes all state for that cycle.
module tdm_demux8 (
    input  logic         clk,
    input  logic         rst,
    tdm_demux8_if.slave  bus
);
    typedef enum logic {HUNT, RECV} state_t;

    state_t     state;
    logic [2:0] slot_r;
    logic [6:0] shadow;
    logic [7:0] out_r;
    logic       frame_valid_r;
    logic       sync_err_r;

    always_ff @(posedge clk) begin
        if (rst) begin
            state         <= HUNT;
            slot_r        <= 3'd0;
            shadow        <= 7'd0;
            out_r         <= 8'h00;
            frame_valid_r <= 1'b0;
            sync_err_r    <= 1'b0;
        end else begin
            frame_valid_r <= 1'b0;
            sync_err_r    <= 1'b0;
            if (bus.din_valid) begin
                case (state)
                    HUNT: begin
                        if (bus.sync) begin
                            shadow <= {6'd0, bus.din};
                            slot_r <= 3'd1;
                            state  <= RECV;
                        end else begin
                            slot_r <= 3'd0;
                        end
                    end
                    RECV: begin
                        if (slot_r == 3'd0) begin
                            if (bus.sync) begin
                                shadow <= {6'd0, bus.din};
                                slot_r <= 3'd1;
                            end else begin
                                // Expected a frame start and got none: alignment lost.
                                sync_err_r <= 1'b1;
                                slot_r     <= 3'd0;
                                state      <= HUNT;
                            end
                        end else if (bus.sync) begin
                            // Early sync: drop the partial frame and realign here.
                            sync_err_r <= 1'b1;
                            shadow     <= {6'd0, bus.din};
                            slot_r     <= 3'd1;
                        end else if (slot_r == 3'd7) begin
                            out_r         <= {bus.din, shadow};
                            frame_valid_r <= 1'b1;
                            slot_r        <= 3'd0;
                        end else begin
                            shadow[slot_r] <= bus.din;
                            slot_r         <= slot_r + 3'd1;
                        end
                    end
                    default: state <= HUNT;
                endcase
            end
        end
    end

    assign bus.out         = out_r;
    assign bus.frame_valid = frame_valid_r;
    assign bus.slot        = slot_r;
    assign bus.locked      = (state == RECV);
    assign bus.sync_err    = sync_err_r;
endmodule
